// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and helpers for the skid-buffer pipeline chain.
//   stage_state_t : occupancy state of one two-entry skid stage
//   CNT_W(depth)  : width of a counter that must hold 0..2*depth
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_t;

    function automatic int CNT_W(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: one registered two-entry skid buffer with valid/ready on
// both sides. up_ready is a flop, so no ready path crosses the stage.
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   flush           : synchronous discard of held words (data regs untouched)
//   up_valid/ready  : upstream handshake, up_data is the offered word
//   down_valid/ready: downstream handshake, down_data is the main entry
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [WIDTH-1:0] down_data
);

    stage_state_t     state_q, state_d;
    logic             ready_q;
    logic [WIDTH-1:0] main_q, skid_q;
    logic             accept, emit;
    logic             load_main, load_skid, shift;

    always_comb begin
        accept    = up_valid && ready_q;
        emit      = (state_q != ST_EMPTY) && down_ready;
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        shift     = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d   = ST_HALF;
                    load_main = 1'b1;
                end
            end
            ST_HALF: begin
                if (accept && emit) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    state_d   = ST_FULL;
                    load_skid = 1'b1;
                end else if (emit) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (emit) begin
                    state_d = ST_HALF;
                    shift   = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // A word offered during flush is dropped, so nothing loads either.
        if (flush) begin
            state_d   = ST_EMPTY;
            load_main = 1'b0;
            load_skid = 1'b0;
            shift     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b1;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            // Registered ready: decoded from the next state, not from down_ready.
            ready_q <= (state_d != ST_FULL);
            if (load_main) begin
                main_q <= up_data;
            end else if (shift) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= up_data;
            end
        end
    end

    assign up_ready   = ready_q;
    assign down_valid = (state_q != ST_EMPTY);
    assign down_data  = main_q;

endmodule

// File: rtl/pipe_skid_chain.sv
// pipe_skid_chain: DEPTH skid stages in series carrying a WIDTH-bit payload,
// with an occupancy counter. Throughput one word per cycle, FIFO order.
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   flush               : synchronous discard of all in-flight words
//   in_valid/in_ready   : upstream handshake, in_data payload
//   out_valid/out_ready : downstream handshake, out_data payload
//   busy                : any word held
//   count               : number of words held (0..2*DEPTH)
module pipe_skid_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      busy,
    output logic [CNT_W(DEPTH)-1:0]   count
);

    localparam int CW = CNT_W(DEPTH);

    logic [DEPTH:0]   link_valid;
    logic [DEPTH:0]   link_ready;
    logic [WIDTH-1:0] link_data [DEPTH+1];
    logic [CW-1:0]    count_q;
    logic             accept, emit;

    assign link_valid[0]     = in_valid;
    assign link_data[0]      = in_data;
    assign in_ready          = link_ready[0];
    assign out_valid         = link_valid[DEPTH];
    assign out_data          = link_data[DEPTH];
    assign link_ready[DEPTH] = out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        pipe_skid_stage #(.WIDTH(WIDTH)) u_stage (
            .clk        (clk),
            .reset      (reset),
            .flush      (flush),
            .up_valid   (link_valid[k]),
            .up_ready   (link_ready[k]),
            .up_data    (link_data[k]),
            .down_valid (link_valid[k+1]),
            .down_ready (link_ready[k+1]),
            .down_data  (link_data[k+1])
        );
    end

    assign accept = in_valid && in_ready;
    assign emit   = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count_q <= '0;
        end else if (accept && !emit) begin
            count_q <= count_q + 1'b1;
        end else if (emit && !accept) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign count = count_q;
    assign busy  = (count_q != '0);

endmodule

// File: tb/tb_pipe_skid_chain.sv
// tb_pipe_skid_chain: scoreboard bench. Stimulus pushes accepted words into a
// queue; a negedge monitor pops on every emit and checks data and count.
module tb_pipe_skid_chain;

    logic        clk = 1'b0;
    logic        reset = 1'b1, flush = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready, out_valid, busy;
    logic [15:0] out_data;
    logic [2:0]  count;

    int compared = 0;
    int mismatched = 0;
    logic [15:0] q[$];
    logic mon_en = 1'b0;

    // samples taken at the negedge of the most recent step
    logic        s_ir, s_ov, s_busy, s_acc;
    logic [15:0] s_od;
    logic [2:0]  s_cnt;

    always #5 clk = ~clk;

    pipe_skid_chain #(.WIDTH(16), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .count(count)
    );

    // parameter sweep instances
    logic        sw_v[2], sw_or[2], sw_ir[2], sw_ov[2], sw_busy[2];
    logic [32:0] sw_d[2], sw_od[2];
    logic [3:0]  sw_cnt[2];
    logic        od_a;
    logic [1:0]  cnt_a;
    logic [32:0] od_b;
    logic [3:0]  cnt_b;
    logic        din_a;

    assign din_a     = sw_d[0][0];
    assign sw_od[0]  = {32'b0, od_a};
    assign sw_cnt[0] = {2'b0, cnt_a};
    assign sw_od[1]  = od_b;
    assign sw_cnt[1] = cnt_b;

    pipe_skid_chain #(.WIDTH(1), .DEPTH(1)) dut_a (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(sw_v[0]), .in_ready(sw_ir[0]), .in_data(din_a),
        .out_valid(sw_ov[0]), .out_ready(sw_or[0]), .out_data(od_a),
        .busy(sw_busy[0]), .count(cnt_a)
    );

    pipe_skid_chain #(.WIDTH(33), .DEPTH(5)) dut_b (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(sw_v[1]), .in_ready(sw_ir[1]), .in_data(sw_d[1]),
        .out_valid(sw_ov[1]), .out_ready(sw_or[1]), .out_data(od_b),
        .busy(sw_busy[1]), .count(cnt_b)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // monitor: count against scoreboard depth, then pop on emit
    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_count", 64'(count), 64'(q.size()));
            if (out_valid && out_ready && !reset) begin
                if (q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL mon_unexpected: got word %0h expected none (t=%0t)", out_data, $time);
                end else begin
                    chk("mon_data", 64'(out_data), 64'(q.pop_front()));
                end
            end
        end
    end

    task automatic step(input logic v, input logic [15:0] d, input logic ordy,
                        input logic fl, input logic rs);
        in_valid = v; in_data = d; out_ready = ordy; flush = fl; reset = rs;
        @(negedge clk);
        s_ir = in_ready; s_ov = out_valid; s_od = out_data;
        s_busy = busy; s_cnt = count;
        s_acc = v && in_ready && !fl && !rs;
        #2;
        if (s_acc) q.push_back(d);
        if (fl || rs) q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    task automatic sw_step(input int i, input logic v, input logic [32:0] d, input logic ordy,
                           output logic ir, output logic ov, output logic [32:0] od,
                           output logic [3:0] cnt);
        sw_v[i] = v; sw_d[i] = d; sw_or[i] = ordy;
        @(negedge clk);
        ir = sw_ir[i]; ov = sw_ov[i]; od = sw_od[i]; cnt = sw_cnt[i];
        @(posedge clk);
        #1;
    endtask

    task automatic sweep_run(input int i, input int depth, input logic [32:0] pat);
        logic ir, ov;
        logic [32:0] od;
        logic [3:0] cnt;
        int lat = -1;
        int nacc = 0;
        sw_step(i, 1'b1, pat, 1'b1, ir, ov, od, cnt);
        chk("sw_first_accept", 64'(ir), 64'd1);
        for (int c = 1; c <= depth + 3; c++) begin
            sw_step(i, 1'b0, '0, 1'b1, ir, ov, od, cnt);
            if (ov && lat < 0) begin
                lat = c;
                chk("sw_data", 64'(od), 64'(pat));
            end
        end
        chk("sw_latency", 64'(lat), 64'(depth));
        for (int c = 0; c < 2 * depth + 4; c++) begin
            sw_step(i, 1'b1, 33'(c), 1'b0, ir, ov, od, cnt);
            if (ir) nacc++;
        end
        chk("sw_capacity", 64'(nacc), 64'(2 * depth));
        chk("sw_full_count", 64'(cnt), 64'(2 * depth));
        chk("sw_full_ready", 64'(ir), 64'd0);
        for (int c = 0; c < 4 * depth + 4; c++) sw_step(i, 1'b0, '0, 1'b1, ir, ov, od, cnt);
        chk("sw_drained_count", 64'(cnt), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nacc;
        int maxc;
        for (int i = 0; i < 2; i++) begin
            sw_v[i] = 1'b0; sw_or[i] = 1'b0; sw_d[i] = '0;
        end

        // reset for two cycles, then reset values
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("rst_in_ready", 64'(s_ir), 64'd1);
        chk("rst_out_valid", 64'(s_ov), 64'd0);
        chk("rst_out_data", 64'(s_od), 64'd0);
        chk("rst_busy", 64'(s_busy), 64'd0);
        chk("rst_count", 64'(s_cnt), 64'd0);
        mon_en = 1'b1;

        // back-to-back stream 0x0001..0x0010
        maxc = 0;
        for (int k = 0; k < 16; k++) begin
            step(1'b1, 16'(k + 1), 1'b1, 1'b0, 1'b0);
            chk("stream_in_ready", 64'(s_ir), 64'd1);
            if (int'(s_cnt) > maxc) maxc = int'(s_cnt);
            if (k == 1) chk("stream_lat_early", 64'(s_ov), 64'd0);
            if (k == 2) begin
                chk("stream_lat_valid", 64'(s_ov), 64'd1);
                chk("stream_lat_data", 64'(s_od), 64'h0001);
            end
        end
        chk("stream_max_count", 64'(maxc), 64'd2);
        drain();

        // full stall, then release
        nacc = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 16'(16'h0100 + k), 1'b0, 1'b0, 1'b0);
            if (s_acc) nacc++;
        end
        chk("stall_accepts", 64'(nacc), 64'd4);
        chk("stall_in_ready", 64'(s_ir), 64'd0);
        chk("stall_count", 64'(s_cnt), 64'd4);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("release_first_emit", 64'(s_ov), 64'd1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("release_ready_low", 64'(s_ir), 64'd0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("release_ready_high", 64'(s_ir), 64'd1);
        drain();

        // random valid/ready
        nacc = 0;
        for (int n = 0; n < 8000 && nacc < 1000; n++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            if (s_acc) nacc++;
        end
        chk("rand_accepts", 64'(nacc), 64'd1000);
        drain();

        // flush a full chain with a word offered in the flush cycle
        for (int k = 0; k < 6; k++) step(1'b1, 16'(16'h0200 + k), 1'b0, 1'b0, 1'b0);
        step(1'b1, 16'hDEAD, 1'b1, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        chk("flush_out_valid", 64'(s_ov), 64'd0);
        chk("flush_count", 64'(s_cnt), 64'd0);
        chk("flush_busy", 64'(s_busy), 64'd0);
        chk("flush_in_ready", 64'(s_ir), 64'd1);
        for (int k = 0; k < 6; k++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // reset with three words held
        for (int k = 0; k < 3; k++) step(1'b1, 16'(16'h0300 + k), 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("mrst_in_ready", 64'(s_ir), 64'd1);
        chk("mrst_out_valid", 64'(s_ov), 64'd0);
        chk("mrst_out_data", 64'(s_od), 64'd0);
        chk("mrst_busy", 64'(s_busy), 64'd0);
        chk("mrst_count", 64'(s_cnt), 64'd0);
        step(1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b0);
        step(1'b1, 16'h5555, 1'b1, 1'b0, 1'b0);
        drain();

        // parameter sweep
        sweep_run(0, 1, 33'h1);
        sweep_run(1, 5, 33'h1_2345_6789);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
